// File: rtl/conv_feeder_if.sv
// Operand, memory and result-stream signals between conv_feeder and its neighbours.
// The feeder is the master; memory, engine and result sink sit on the slave side.
interface conv_feeder_if #(
  parameter int ADDR_W = 12
) ();
  logic                     mem_en;
  logic [ADDR_W-1:0]        mem_addr;
  logic signed [8:0]        mem_rdata;
  logic [188:0]             k_bus;
  logic [188:0]             x_bus;
  logic                     conv_start;
  logic                     conv_done;
  logic signed [25:0]       conv_result;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [25:0]       out_data;
  logic [7:0]               out_index;

  modport master (
    output mem_en, mem_addr, k_bus, x_bus, conv_start, out_valid, out_data, out_index,
    input  mem_rdata, conv_done, conv_result, out_ready
  );

  modport slave (
    input  mem_en, mem_addr, k_bus, x_bus, conv_start, out_valid, out_data, out_index,
    output mem_rdata, conv_done, conv_result, out_ready
  );
endinterface

// File: rtl/conv_feeder.sv
// Job sequencer for the 21-tap convolution engine: loads kernel once, then per window
// loads pixels, runs the engine, and returns the result over a valid/ready stream.
module conv_feeder #(
  parameter int ADDR_W      = 12,
  parameter int NUM_WINDOWS = 8,
  parameter int STRIDE      = 21,
  parameter int KBASE       = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_start,
  input  logic [ADDR_W-1:0] job_base,
  output logic              busy,
  output logic              job_done,
  output logic              timeout_err,
  conv_feeder_if.master     bus
);

  localparam int TAPS   = 21;
  localparam int DATA_W = 9;
  localparam int RES_W  = 26;
  localparam int RC_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [4:0]      LAST_IDX = 5'(TAPS);
  localparam logic [7:0]      LAST_WIN = 8'(NUM_WINDOWS - 1);
  localparam logic [RC_W-1:0] TO_LAST  = RC_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_K,
    S_LOAD_X,
    S_RUN,
    S_GAP,
    S_OUT,
    S_FIN
  } state_e;

  state_e                          state_q, state_d;
  logic [4:0]                      idx_q, idx_d;
  logic [7:0]                      win_q, win_d;
  logic [ADDR_W-1:0]               base_q, base_d;
  logic [ADDR_W-1:0]               woff_q, woff_d;
  logic [RC_W-1:0]                 run_q, run_d;
  logic [TAPS-1:0][DATA_W-1:0]     k_q, k_d;
  logic [TAPS-1:0][DATA_W-1:0]     x_q, x_d;
  logic signed [RES_W-1:0]         out_data_q, out_data_d;
  logic                            terr_q, terr_d;
  logic                            vld_p1_q, vld_p1_d;
  logic [4:0]                      idx_p1_q, idx_p1_d;
  logic                            rd_phase;

  // Address arithmetic is modulo 2^ADDR_W so pixel windows wrap silently.
  function automatic logic [ADDR_W-1:0] rd_addr(input logic [ADDR_W-1:0] base,
                                                input logic [ADDR_W-1:0] off,
                                                input logic [4:0]        idx);
    return base + off + ADDR_W'(idx);
  endfunction

  assign rd_phase = ((state_q == S_LOAD_K) || (state_q == S_LOAD_X)) && (idx_q != LAST_IDX);

  always_comb begin
    bus.mem_en   = rd_phase;
    bus.mem_addr = '0;
    if (rd_phase) begin
      if (state_q == S_LOAD_K) bus.mem_addr = rd_addr(ADDR_W'(KBASE), '0, idx_q);
      else                     bus.mem_addr = rd_addr(base_q, woff_q, idx_q);
    end
  end

  assign bus.k_bus      = k_q;
  assign bus.x_bus      = x_q;
  assign bus.conv_start = (state_q == S_RUN);
  assign bus.out_valid  = (state_q == S_OUT);
  assign bus.out_data   = out_data_q;
  assign bus.out_index  = win_q;
  assign busy           = (state_q != S_IDLE);
  assign job_done       = (state_q == S_FIN);
  assign timeout_err    = terr_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    win_d      = win_q;
    base_d     = base_q;
    woff_d     = woff_q;
    run_d      = run_q;
    k_d        = k_q;
    x_d        = x_q;
    out_data_d = out_data_q;
    terr_d     = terr_q;
    vld_p1_d   = rd_phase;
    idx_p1_d   = idx_q;

    // Read data lands one cycle after its strobe; route it by the current load phase.
    if (vld_p1_q) begin
      if (state_q == S_LOAD_K)      k_d[idx_p1_q] = bus.mem_rdata;
      else if (state_q == S_LOAD_X) x_d[idx_p1_q] = bus.mem_rdata;
    end

    case (state_q)
      S_IDLE: begin
        if (job_start) begin
          state_d = S_LOAD_K;
          base_d  = job_base;
          win_d   = '0;
          woff_d  = '0;
          idx_d   = '0;
          terr_d  = 1'b0;
        end
      end
      S_LOAD_K: begin
        idx_d = idx_q + 5'd1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_LOAD_X;
        end
      end
      S_LOAD_X: begin
        idx_d = idx_q + 5'd1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          run_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A completion on the final allowed cycle wins over the timeout.
        if (bus.conv_done) begin
          out_data_d = bus.conv_result;
          state_d    = S_GAP;
        end else if (run_q == TO_LAST) begin
          out_data_d = '0;
          terr_d     = 1'b1;
          state_d    = S_GAP;
        end else begin
          run_d = run_q + 1'b1;
        end
      end
      S_GAP: begin
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          win_d  = win_q + 8'd1;
          woff_d = woff_q + ADDR_W'(STRIDE);
          idx_d  = '0;
          state_d = (win_q == LAST_WIN) ? S_FIN : S_LOAD_X;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      win_q      <= '0;
      base_q     <= '0;
      woff_q     <= '0;
      run_q      <= '0;
      k_q        <= '0;
      x_q        <= '0;
      out_data_q <= '0;
      terr_q     <= 1'b0;
      vld_p1_q   <= 1'b0;
      idx_p1_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      win_q      <= win_d;
      base_q     <= base_d;
      woff_q     <= woff_d;
      run_q      <= run_d;
      k_q        <= k_d;
      x_q        <= x_d;
      out_data_q <= out_data_d;
      terr_q     <= terr_d;
      vld_p1_q   <= vld_p1_d;
      idx_p1_q   <= idx_p1_d;
    end
  end

endmodule

// File: tb/tb_conv_feeder.sv
// Directed bench for conv_feeder: a 3-window instance with a behavioural engine and
// a 1-window, TIMEOUT=10 instance whose engine never completes.
module tb_conv_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        js_a, js_b;
  logic [11:0] jb_a, jb_b;
  logic        busy_a, done_a, terr_a;
  logic        busy_b, done_b, terr_b;

  conv_feeder_if #(.ADDR_W(12)) bus_a ();
  conv_feeder_if #(.ADDR_W(12)) bus_b ();

  conv_feeder #(.ADDR_W(12), .NUM_WINDOWS(3), .STRIDE(21), .KBASE(0), .TIMEOUT(255)) dut_a (
    .clk(clk), .reset(reset), .job_start(js_a), .job_base(jb_a),
    .busy(busy_a), .job_done(done_a), .timeout_err(terr_a), .bus(bus_a.master)
  );

  conv_feeder #(.ADDR_W(12), .NUM_WINDOWS(1), .STRIDE(21), .KBASE(0), .TIMEOUT(10)) dut_b (
    .clk(clk), .reset(reset), .job_start(js_b), .job_base(jb_b),
    .busy(busy_b), .job_done(done_b), .timeout_err(terr_b), .bus(bus_b.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int mem_mode = 0;
  logic [11:0] rd_log[$];
  int jd_a = 0;
  int run_b = 0;
  logic signed [31:0] acc_a;
  int cnt_a;

  // Sample memory for instance A: mode 0 gives kernel 1 then pixels 2, mode 1 gives addr mod 256.
  always @(posedge clk) begin
    if (bus_a.mem_en) begin
      if (mem_mode == 0) bus_a.mem_rdata <= (rd_log.size() < 21) ? 9'sd1 : 9'sd2;
      else               bus_a.mem_rdata <= $signed({1'b0, bus_a.mem_addr[7:0]});
      rd_log.push_back(bus_a.mem_addr);
    end
  end

  function automatic logic signed [31:0] dot21(input logic [188:0] k, input logic [188:0] x);
    logic signed [31:0] s;
    s = 0;
    for (int i = 0; i < 21; i++) s = s + $signed(k[9*i +: 9]) * $signed(x[9*i +: 9]);
    return s;
  endfunction

  // Behavioural engine: accumulates the dot product each start cycle, done after 20.
  always @(posedge clk) begin
    if (!bus_a.conv_start) begin
      acc_a <= 0;
      cnt_a <= 0;
    end else begin
      acc_a <= acc_a + dot21(bus_a.k_bus, bus_a.x_bus);
      cnt_a <= cnt_a + 1;
    end
  end
  assign bus_a.conv_done   = bus_a.conv_start && (cnt_a == 20);
  assign bus_a.conv_result = acc_a[25:0];

  always @(posedge clk) if (done_a) jd_a <= jd_a + 1;

  always @(posedge clk) if (bus_b.mem_en) bus_b.mem_rdata <= '0;
  assign bus_b.conv_done   = 1'b0;
  assign bus_b.conv_result = '0;
  always @(posedge clk) if (bus_b.conv_start) run_b <= run_b + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_valid_a(output int n);
    bit found;
    found = 0;
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n++;
      if (bus_a.out_valid) begin
        found = 1;
        break;
      end
    end
    check_eq("valid_a_wait", found, 1);
  endtask

  task automatic take_a(input int stall, output logic [25:0] d, output logic [7:0] ix, output int lat);
    bit sbad;
    wait_valid_a(lat);
    d = bus_a.out_data;
    ix = bus_a.out_index;
    sbad = 0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!bus_a.out_valid || bus_a.out_data !== d || bus_a.out_index !== ix ||
          bus_a.mem_en || bus_a.conv_start) sbad = 1;
    end
    if (stall > 0) check_eq("stall_hold", sbad, 0);
    bus_a.out_ready = 1'b1;
    @(posedge clk);
    #1 bus_a.out_ready = 1'b0;
  endtask

  task automatic start_a(input logic [11:0] base);
    @(negedge clk);
    jb_a = base;
    js_a = 1'b1;
    @(posedge clk);
    #1 js_a = 1'b0;
  endtask

  initial begin
    logic [25:0] d;
    logic [7:0]  ix;
    int lat, rb, jd0, rs;
    bit found;

    reset = 1'b1;
    js_a = 1'b0; js_b = 1'b0;
    jb_a = '0;   jb_b = '0;
    bus_a.out_ready = 1'b0;
    bus_b.out_ready = 1'b1;
    mem_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_ctrl", {bus_a.mem_en, bus_a.conv_start, bus_a.out_valid, done_a, terr_a}, 0);
    check_eq("rst_data", bus_a.out_data, 0);
    check_eq("rst_bus", (bus_a.k_bus != '0) || (bus_a.x_bus != '0) || (bus_a.mem_addr != '0), 0);
    check_eq("rst_b", {busy_b, terr_b, bus_b.conv_start}, 0);
    @(negedge clk) reset = 1'b0;

    // Kernel of ones, pixels of twos, base 0.
    @(negedge clk);
    jb_a = 12'd0;
    js_a = 1'b1;
    check_eq("t1_busy_pre", busy_a, 0);
    @(posedge clk);
    #1 js_a = 1'b0;
    check_eq("t1_busy_rise", busy_a, 1);
    jd0 = jd_a;
    take_a(0, d, ix, lat);
    check_eq("t1_lat_w0", lat, 67);
    check_eq("t1_w0_data", d, 840);
    check_eq("t1_w0_idx", ix, 0);
    take_a(0, d, ix, lat);
    check_eq("t1_w1_data", d, 840);
    check_eq("t1_w1_idx", ix, 1);
    take_a(0, d, ix, lat);
    check_eq("t1_w2_data", d, 840);
    check_eq("t1_w2_idx", ix, 2);
    @(negedge clk);
    check_eq("t1_job_done", done_a, 1);
    @(negedge clk);
    check_eq("t1_idle", {busy_a, done_a}, 0);
    check_eq("t1_done_cnt", jd_a - jd0, 1);

    // Ramp memory, base 100, back-pressure on window 1.
    mem_mode = 1;
    rb = rd_log.size();
    start_a(12'd100);
    take_a(0, d, ix, lat);
    check_eq("t2_w0_data", d, 477400);
    check_eq("t2_w0_idx", ix, 0);
    take_a(50, d, ix, lat);
    check_eq("t2_w1_data", d, 565600);
    check_eq("t2_w1_idx", ix, 1);
    take_a(0, d, ix, lat);
    check_eq("t2_w2_data", d, 653800);
    check_eq("t2_w2_idx", ix, 2);
    @(negedge clk);
    check_eq("t2_job_done", done_a, 1);
    check_eq("t2_addr_w0", rd_log[rb+21], 100);
    check_eq("t2_addr_w2_first", rd_log[rb+63], 142);
    check_eq("t2_addr_w2_last", rd_log[rb+83], 162);
    check_eq("t2_read_cnt", rd_log.size() - rb, 84);

    // Base near the top of memory: window 0 wraps.
    @(negedge clk);
    rb = rd_log.size();
    start_a(12'd4091);
    for (int w = 0; w < 3; w++) take_a(0, d, ix, lat);
    @(negedge clk);
    check_eq("t3_addr_first", rd_log[rb+21], 4091);
    check_eq("t3_addr_top", rd_log[rb+25], 4095);
    check_eq("t3_addr_wrap", rd_log[rb+26], 0);
    check_eq("t3_addr_last", rd_log[rb+41], 15);
    check_eq("t3_no_err", terr_a, 0);
    @(negedge clk);

    // Reset during the RUN of window 1, then a fresh job.
    start_a(12'd100);
    take_a(0, d, ix, lat);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_a.conv_start) begin
        found = 1;
        break;
      end
    end
    check_eq("t4_run_w1", found, 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t4_rst_ctrl", {busy_a, bus_a.mem_en, bus_a.conv_start, bus_a.out_valid, done_a, terr_a}, 0);
    check_eq("t4_rst_data", bus_a.out_data, 0);
    check_eq("t4_rst_idx", bus_a.out_index, 0);
    check_eq("t4_rst_bus", (bus_a.k_bus != '0) || (bus_a.x_bus != '0), 0);
    @(negedge clk) reset = 1'b0;
    jd0 = jd_a;
    start_a(12'd100);
    take_a(0, d, ix, lat);
    check_eq("t4_w0_data", d, 477400);
    take_a(0, d, ix, lat);
    check_eq("t4_w1_data", d, 565600);
    take_a(0, d, ix, lat);
    check_eq("t4_w2_idx", ix, 2);
    @(negedge clk);
    check_eq("t4_job_done", done_a, 1);
    @(negedge clk);
    check_eq("t4_done_cnt", jd_a - jd0, 1);

    // Engine that never completes, TIMEOUT=10.
    rs = run_b;
    @(negedge clk);
    jb_b = 12'd0;
    js_b = 1'b1;
    @(posedge clk);
    #1 js_b = 1'b0;
    found = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus_b.out_valid) begin
        found = 1;
        break;
      end
    end
    check_eq("t5_valid_wait", found, 1);
    check_eq("t5_run_cycles", run_b - rs, 10);
    check_eq("t5_data_zero", bus_b.out_data, 0);
    check_eq("t5_err_set", terr_b, 1);
    @(negedge clk);
    check_eq("t5_job_done", done_b, 1);
    @(negedge clk);
    check_eq("t5_err_sticky", terr_b, 1);
    js_b = 1'b1;
    @(posedge clk);
    #1 js_b = 1'b0;
    check_eq("t5_err_clear", terr_b, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
